led_matrix_pwm_scanner: RTL and testbench

Parametrised next-generation LED matrix driver. It accepts a serial frame on the `din`/`dclk`/`strobe` pins (asynchronous to `clk`) and double-buffers it, swapping buffers only at frame boundaries so the display never tears. It then scans the matrix one row at a time, applying per-pixel PWM brightness and a blanking gap between rows to suppress ghosting. It sits directly behind the top-level `ui_in[2:0]` pins and drives the row and column pins.

---
 rtl/led_matrix_pwm_scanner.sv | 119 +++++++++++
 tb/tb_led_matrix_pwm_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_matrix_pwm_scanner.sv
// led_matrix_pwm_scanner: serial-loaded, double-buffered LED matrix row scanner with per-pixel PWM
module led_matrix_pwm_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int PWM_BITS     = 2,
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            din,
    input  logic            dclk,
    input  logic            strobe,
    output logic [ROWS-1:0] row_out,
    output logic [COLS-1:0] col_out,
    output logic            frame_sync,
    output logic            latch_done
);
    localparam int N  = ROWS * COLS * PWM_BITS;
    localparam int RW = $clog2(ROWS);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, ON} state_t;
    state_t state, state_nxt;

    logic [1:0]          din_s;
    logic [2:0]          dclk_s, strobe_s;
    logic                dclk_rise, strobe_rise;
    logic [N-1:0]        shreg, pending, display;
    logic                pend_valid, fs_q;
    logic [RW-1:0]       row;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PW-1:0]       pre_cnt;
    logic [BW-1:0]       blank_cnt;
    logic                blank_done, pre_wrap, row_done, frame_wrap;

    // the third flop of each clock-like chain holds the previous synchronised level for edge detection
    assign dclk_rise   = dclk_s[1] & ~dclk_s[2];
    assign strobe_rise = strobe_s[1] & ~strobe_s[2];
    assign frame_sync  = fs_q & ena;

    // synchronise the asynchronous serial pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_s    <= '0;
            dclk_s   <= '0;
            strobe_s <= '0;
        end else begin
            din_s    <= {din_s[0], din};
            dclk_s   <= {dclk_s[1:0], dclk};
            strobe_s <= {strobe_s[1:0], strobe};
        end
    end

    // shift, latch into the pending buffer, and swap to the display buffer only on a frame wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            pending    <= '0;
            display    <= '0;
            pend_valid <= 1'b0;
            latch_done <= 1'b0;
        end else begin
            latch_done <= strobe_rise;
            if (dclk_rise) shreg <= {shreg[N-2:0], din_s[1]};
            if (strobe_rise) pending <= shreg;
            if (frame_wrap && pend_valid) display <= pending;
            pend_valid <= strobe_rise ? 1'b1 : frame_wrap ? 1'b0 : pend_valid;
        end
    end

    // scan state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= BLANK;
        else state <= state_nxt;
    end

    // next-state and counter wrap conditions; everything is gated by ena so the scan freezes in place
    always_comb begin
        blank_done = ena && state == BLANK && blank_cnt == BLANK_LAST;
        pre_wrap   = ena && state == ON && pre_cnt == PRE_LAST;
        row_done   = pre_wrap && (&pwm_cnt);
        frame_wrap = row_done && row == ROW_LAST;
        state_nxt  = blank_done ? ON : row_done ? BLANK : state;
    end

    // scan counters; pwm_cnt wraps to zero naturally at the end of a row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row       <= '0;
            pwm_cnt   <= '0;
            pre_cnt   <= '0;
            blank_cnt <= '0;
            fs_q      <= 1'b0;
        end else begin
            blank_cnt <= blank_done ? '0 : (ena && state == BLANK) ? blank_cnt + 1'b1 : blank_cnt;
            pre_cnt   <= (pre_wrap || blank_done) ? '0 : (ena && state == ON) ? pre_cnt + 1'b1 : pre_cnt;
            pwm_cnt   <= blank_done ? '0 : pre_wrap ? pwm_cnt + 1'b1 : pwm_cnt;
            row       <= frame_wrap ? '0 : row_done ? row + 1'b1 : row;
            fs_q      <= ena ? frame_wrap : fs_q;
        end
    end

    // decode row and column drive straight from the registered scan state
    always_comb begin
        row_out = '0;
        col_out = '0;
        if (ena && state == ON) begin
            row_out[row] = 1'b1;
            for (int c = 0; c < COLS; c++)
                col_out[c] = display[(int'(row) * COLS + c) * PWM_BITS +: PWM_BITS] > pwm_cnt;
        end
    end
endmodule

// File: tb/tb_led_matrix_pwm_scanner.sv
// tb_led_matrix_pwm_scanner: randomized directed bench against a time-based behavioural model
module tb_led_matrix_pwm_scanner;
    localparam int R = 2, C = 2, B = 2, PS = 1, BL = 1;
    localparam int N = R * C * B;
    localparam int P = BL + (1 << B) * PS;
    localparam int F = P * R;

    logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b1, din = 1'b0, dclk = 1'b0, strobe = 1'b0;
    logic [R-1:0] row_out;
    logic [C-1:0] col_out;
    logic         frame_sync, latch_done;
    int           checks = 0, failures = 0;

    led_matrix_pwm_scanner #(.ROWS(R), .COLS(C), .PWM_BITS(B), .PRESCALE(PS), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .dclk(dclk), .strobe(strobe),
        .row_out(row_out), .col_out(col_out), .frame_sync(frame_sync), .latch_done(latch_done)
    );

    always #5 clk = ~clk;

    // model state: pin history (index 0 = this edge), received bits, buffers as pixel arrays, scan time
    int h_dclk[4], h_str[4], h_din[4];
    int bitq[$];
    int pend[R][C], disp[R][C];
    bit pvalid, fs_e, ld_e;
    int t;

    function automatic int sh_pix(int r, int c);
        int v = 0;
        for (int b = 0; b < B; b++) begin
            int i = (r * C + c) * B + b;
            if (i < bitq.size() && bitq[bitq.size() - 1 - i] != 0) v += 1 << b;
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit dr, sr;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin h_dclk[k] = 0; h_str[k] = 0; h_din[k] = 0; end
            bitq.delete();
            for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin pend[r][c] = 0; disp[r][c] = 0; end
            pvalid = 0; fs_e = 0; ld_e = 0; t = 0;
        end else begin
            for (int k = 3; k > 0; k--) begin h_dclk[k] = h_dclk[k-1]; h_str[k] = h_str[k-1]; h_din[k] = h_din[k-1]; end
            h_dclk[0] = int'(dclk); h_str[0] = int'(strobe); h_din[0] = int'(din);
            dr = h_dclk[2] == 1 && h_dclk[3] == 0;
            sr = h_str[2] == 1 && h_str[3] == 0;
            if (ena) begin
                t++;
                if (t % F == 0) begin
                    if (pvalid) disp = pend;
                    pvalid = 0;
                end
                fs_e = (t % F == 0);
            end
            ld_e = sr;
            if (sr) begin
                for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) pend[r][c] = sh_pix(r, c);
                pvalid = 1;
            end
            if (dr) begin
                bitq.push_back(h_din[2]);
                if (bitq.size() > N) void'(bitq.pop_front());
            end
        end
    end

    task automatic check_all();
        logic [R-1:0] re;
        logic [C-1:0] ce;
        int ph, rw, sl;
        bit on;
        ph = t % P; rw = (t / P) % R; sl = (ph - BL) / PS;
        on = ena && ph >= BL;
        re = '0; ce = '0;
        if (on) begin
            re[rw] = 1'b1;
            for (int c = 0; c < C; c++) ce[c] = disp[rw][c] > sl;
        end
        checks++;
        assert (row_out === re) else begin failures++; $error("FAIL row_out t=%0d got %b exp %b", t, row_out, re); end
        checks++;
        assert (col_out === ce) else begin failures++; $error("FAIL col_out t=%0d got %b exp %b", t, col_out, ce); end
        checks++;
        assert (frame_sync === (fs_e && ena)) else begin failures++; $error("FAIL frame_sync t=%0d got %b exp %b", t, frame_sync, fs_e && ena); end
        checks++;
        assert (latch_done === ld_e) else begin failures++; $error("FAIL latch_done t=%0d got %b exp %b", t, latch_done, ld_e); end
    endtask

    task automatic tick(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic send_bit(logic b);
        din = b; dclk = 1'b1; tick(2);
        dclk = 1'b0; tick(2);
    endtask

    task automatic send_frame(logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic strobe_pulse();
        strobe = 1'b1; tick(2);
        strobe = 1'b0; tick(2);
    endtask

    task automatic wait_row1();
        int k = 0;
        while (row_out !== 2'b10 && k < 40) begin tick(1); k++; end
        checks++;
        assert (row_out === 2'b10) else begin failures++; $error("FAIL wait_row1 got %b exp 10", row_out); end
    endtask

    initial begin
        int n;
        @(negedge clk);
        tick(3);
        rst_n = 1'b1;
        n = 0;
        do begin tick(1); n++; end while (frame_sync !== 1'b1 && n < 30);
        checks++;
        assert (n == 10) else begin failures++; $error("FAIL first_frame_sync got %0d exp 10", n); end

        send_frame(8'b11_10_01_00);
        strobe = 1'b1; tick(3);
        checks++;
        assert (latch_done === 1'b1) else begin failures++; $error("FAIL latch_delay got %b exp 1", latch_done); end
        strobe = 1'b0; tick(25);

        send_frame(N'($urandom));
        wait_row1();
        strobe_pulse();
        tick(20);

        ena = 1'b0;
        send_frame(N'($urandom));
        strobe_pulse();
        send_frame(N'($urandom));
        strobe_pulse();
        ena = 1'b1;
        tick(25);

        din = 1'b1; dclk = 1'b1; strobe = 1'b1; tick(2);
        dclk = 1'b0; strobe = 1'b0; tick(24);
        strobe_pulse();
        tick(22);

        repeat (5) begin
            send_frame(N'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                ena = 1'b0; tick($urandom_range(1, 6)); ena = 1'b1;
            end
            strobe_pulse();
            tick($urandom_range(5, 25));
        end

        wait_row1();
        tick(1);
        ena = 1'b0; tick(5);
        ena = 1'b1; tick(8);
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1; tick(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
